// File: rtl/enigma_pkg.sv
// Shared types and default constants for the Enigma rotor controller.
package enigma_pkg;

    // Letter / rotor position encoding (0..25 valid, 31 marks an error result)
    typedef logic [4:0] letter_t;

    localparam int unsigned ALPHA_DEF  = 26;
    localparam int unsigned NOTCH0_DEF = 16;
    localparam int unsigned NOTCH1_DEF = 4;

    localparam letter_t ERR_LETTER = 5'd31;

    typedef enum logic [1:0] {
        OpEncrypt = 2'b00,
        OpSetPos  = 2'b01,
        OpZero    = 2'b10,
        OpNop     = 2'b11
    } cmd_op_e;

    typedef enum logic [3:0] {
        StIdle,
        StStep,
        StF0,
        StF1,
        StF2,
        StRefl,
        StB2,
        StB1,
        StB0,
        StDone
    } state_e;

endpackage

// File: rtl/enigma_stepper.sv
// Combinational rotor stepping: odometer advance with the rotor-1 double step.
module enigma_stepper
    import enigma_pkg::*;
#(
    parameter int unsigned ALPHA  = ALPHA_DEF,
    parameter int unsigned NOTCH0 = NOTCH0_DEF,
    parameter int unsigned NOTCH1 = NOTCH1_DEF
) (
    input  letter_t pos0_i,
    input  letter_t pos1_i,
    input  letter_t pos2_i,
    output letter_t pos0_o,
    output letter_t pos1_o,
    output letter_t pos2_o
);

    localparam letter_t LastPos = letter_t'(ALPHA - 1);
    localparam letter_t Notch0  = letter_t'(NOTCH0);
    localparam letter_t Notch1  = letter_t'(NOTCH1);

    function automatic letter_t inc_wrap(input letter_t p);
        return (p == LastPos) ? '0 : p + 5'd1;
    endfunction

    // All advance conditions look at the pre-step positions only
    always_comb begin
        pos0_o = inc_wrap(pos0_i);
        pos1_o = ((pos0_i == Notch0) || (pos1_i == Notch1)) ? inc_wrap(pos1_i) : pos1_i;
        pos2_o = (pos1_i == Notch1) ? inc_wrap(pos2_i) : pos2_i;
    end

endmodule

// File: rtl/enigma_ctrl.sv
// Enigma controller: accepts commands, steps rotors and sequences the external
// stage datapath through forward, reflector and backward passes.
module enigma_ctrl
    import enigma_pkg::*;
#(
    parameter int unsigned NOTCH0 = NOTCH0_DEF,
    parameter int unsigned NOTCH1 = NOTCH1_DEF,
    parameter int unsigned ALPHA  = ALPHA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_sel,
    input  logic [4:0]  cmd_data,
    output logic [1:0]  dp_sel,
    output logic        dp_dir,
    output logic [4:0]  dp_in,
    output logic [4:0]  dp_offset,
    input  logic [4:0]  dp_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_data,
    output logic        res_err,
    output logic [14:0] pos
);

    localparam letter_t AlphaSize = letter_t'(ALPHA);

    state_e  state_q, state_d;
    letter_t data_q, data_d;
    logic    err_q, err_d;
    letter_t pos0_q, pos0_d;
    letter_t pos1_q, pos1_d;
    letter_t pos2_q, pos2_d;

    letter_t step0, step1, step2;
    logic    data_ok;
    cmd_op_e op;

    assign data_ok = (cmd_data < AlphaSize);
    assign op      = cmd_op_e'(cmd_op);

    enigma_stepper #(
        .ALPHA  (ALPHA),
        .NOTCH0 (NOTCH0),
        .NOTCH1 (NOTCH1)
    ) u_stepper (
        .pos0_i (pos0_q),
        .pos1_i (pos1_q),
        .pos2_i (pos2_q),
        .pos0_o (step0),
        .pos1_o (step1),
        .pos2_o (step2)
    );

    // State, data register and rotor positions; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            err_q   <= 1'b0;
            pos0_q  <= '0;
            pos1_q  <= '0;
            pos2_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            pos0_q  <= pos0_d;
            pos1_q  <= pos1_d;
            pos2_q  <= pos2_d;
        end
    end

    // Next-state: command decode in IDLE, one stage per cycle, hold in DONE until consumed
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        pos0_d  = pos0_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (op)
                        OpEncrypt: begin
                            if (data_ok) begin
                                data_d  = cmd_data;
                                state_d = StStep;
                            end else begin
                                // Invalid letter: report immediately, rotors untouched
                                data_d  = ERR_LETTER;
                                err_d   = 1'b1;
                                state_d = StDone;
                            end
                        end
                        OpSetPos: begin
                            if (data_ok) begin
                                case (cmd_sel)
                                    2'd0:    pos0_d = cmd_data;
                                    2'd1:    pos1_d = cmd_data;
                                    2'd2:    pos2_d = cmd_data;
                                    default: ;
                                endcase
                            end
                        end
                        OpZero: begin
                            pos0_d = '0;
                            pos1_d = '0;
                            pos2_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            StStep: begin
                pos0_d  = step0;
                pos1_d  = step1;
                pos2_d  = step2;
                state_d = StF0;
            end
            StF0: begin
                data_d  = dp_out;
                state_d = StF1;
            end
            StF1: begin
                data_d  = dp_out;
                state_d = StF2;
            end
            StF2: begin
                data_d  = dp_out;
                state_d = StRefl;
            end
            StRefl: begin
                data_d  = dp_out;
                state_d = StB2;
            end
            StB2: begin
                data_d  = dp_out;
                state_d = StB1;
            end
            StB1: begin
                data_d  = dp_out;
                state_d = StB0;
            end
            StB0: begin
                data_d  = dp_out;
                state_d = StDone;
            end
            StDone: begin
                if (res_ready) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage select / direction decode; non-stage states park on rotor 0 forward
    always_comb begin
        dp_sel = 2'd0;
        dp_dir = 1'b0;
        case (state_q)
            StF0:   dp_sel = 2'd0;
            StF1:   dp_sel = 2'd1;
            StF2:   dp_sel = 2'd2;
            StRefl: dp_sel = 2'd3;
            StB2: begin
                dp_sel = 2'd2;
                dp_dir = 1'b1;
            end
            StB1: begin
                dp_sel = 2'd1;
                dp_dir = 1'b1;
            end
            StB0: begin
                dp_sel = 2'd0;
                dp_dir = 1'b1;
            end
            default: ;
        endcase
    end

    // Offset of the selected rotor; the reflector has none
    always_comb begin
        dp_offset = '0;
        case (dp_sel)
            2'd0:    dp_offset = pos0_q;
            2'd1:    dp_offset = pos1_q;
            2'd2:    dp_offset = pos2_q;
            default: dp_offset = '0;
        endcase
    end

    assign dp_in     = data_q;
    assign res_data  = data_q;
    assign res_err   = err_q;
    assign res_valid = (state_q == StDone);
    assign cmd_ready = (state_q == StIdle);
    assign pos       = {pos2_q, pos1_q, pos0_q};

endmodule

// File: tb/tb_enigma_ctrl.sv
// Directed bench for enigma_ctrl with a simple behavioural stage datapath.
module tb_enigma_ctrl;
    import enigma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_sel;
    logic [4:0]  cmd_data;
    logic [1:0]  dp_sel;
    logic        dp_dir;
    logic [4:0]  dp_in;
    logic [4:0]  dp_offset;
    logic [4:0]  dp_out;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_data;
    logic        res_err;
    logic [14:0] pos;

    int checks   = 0;
    int failures = 0;

    int exp_sel[7] = '{0, 1, 2, 3, 2, 1, 0};
    int exp_dir[7] = '{0, 0, 0, 0, 1, 1, 1};
    int exp_din[7] = '{0, 2, 3, 4, 21, 23, 25};
    int exp_off[7] = '{1, 0, 0, 0, 0, 0, 1};

    enigma_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sel   (cmd_sel),
        .cmd_data  (cmd_data),
        .dp_sel    (dp_sel),
        .dp_dir    (dp_dir),
        .dp_in     (dp_in),
        .dp_offset (dp_offset),
        .dp_out    (dp_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    // Toy stage: forward adds offset+1, reflector mirrors, backward adds offset+2
    function automatic int dp_model(input int sel, input int dir, input int din, input int off);
        if (sel == 3) return (din < 26) ? 25 - din : 0;
        if (dir == 0) return (din + off + 1) % 26;
        return (din + off + 2) % 26;
    endfunction

    always_comb dp_out = 5'(dp_model(int'(dp_sel), int'(dp_dir), int'(dp_in), int'(dp_offset)));

    function automatic int ref_enc(input int l, input int p0, input int p1, input int p2);
        int v;
        v = dp_model(0, 0, l, p0);
        v = dp_model(1, 0, v, p1);
        v = dp_model(2, 0, v, p2);
        v = dp_model(3, 0, v, 0);
        v = dp_model(2, 1, v, p2);
        v = dp_model(1, 1, v, p1);
        v = dp_model(0, 1, v, p0);
        return v;
    endfunction

    function automatic logic [14:0] mkpos(input int p2, input int p1, input int p0);
        return {5'(p2), 5'(p1), 5'(p0)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] sel, input logic [4:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        for (int i = 0; i < 20 && !res_valid; i++) tick();
        check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic ack();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic encrypt_full(input string tag, input int l, input int p2, input int p1,
                                input int p0);
        send(OpEncrypt, 2'd0, 5'(l));
        wait_result(tag);
        check_eq({tag, "_pos"}, 32'(pos), 32'(mkpos(p2, p1, p0)));
        check_eq({tag, "_data"}, 32'(res_data), 32'(ref_enc(l, p0, p1, p2)));
        check_eq({tag, "_err"}, 32'(res_err), 32'd0);
        ack();
        check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
        cmd_sel   = 2'd0;
        cmd_data  = 5'd0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_data", 32'(res_data), 32'd0);
        check_eq("rst_res_err", 32'(res_err), 32'd0);
        check_eq("rst_dp_sel", 32'(dp_sel), 32'd0);
        check_eq("rst_dp_dir", 32'(dp_dir), 32'd0);
        check_eq("rst_dp_in", 32'(dp_in), 32'd0);
        check_eq("rst_dp_offset", 32'(dp_offset), 32'd0);
        check_eq("rst_pos", 32'(pos), 32'd0);

        // ENCRYPT 0 with a cycle-by-cycle stage trace; accept edge is edge 1
        cmd_valid = 1'b1;
        cmd_op    = OpEncrypt;
        cmd_data  = 5'd0;
        tick();
        cmd_valid = 1'b0;
        check_eq("step_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("step_res_valid", 32'(res_valid), 32'd0);
        tick();
        for (int k = 0; k < 7; k++) begin
            if (k == 0) check_eq("t1_pos", 32'(pos), 32'(mkpos(0, 0, 1)));
            check_eq($sformatf("t1_sel%0d", k), 32'(dp_sel), 32'(exp_sel[k]));
            check_eq($sformatf("t1_dir%0d", k), 32'(dp_dir), 32'(exp_dir[k]));
            check_eq($sformatf("t1_din%0d", k), 32'(dp_in), 32'(exp_din[k]));
            check_eq($sformatf("t1_off%0d", k), 32'(dp_offset), 32'(exp_off[k]));
            if (k < 6) tick();
        end
        check_eq("t1_res_valid_e8", 32'(res_valid), 32'd0);
        tick();
        check_eq("t1_res_valid_e9", 32'(res_valid), 32'd1);
        check_eq("t1_res_data", 32'(res_data), 32'd2);
        check_eq("t1_res_err", 32'(res_err), 32'd0);
        check_eq("t1_done_sel", 32'(dp_sel), 32'd0);
        check_eq("t1_done_dir", 32'(dp_dir), 32'd0);
        ack();
        check_eq("t1_ready_after", 32'(cmd_ready), 32'd1);
        check_eq("t1_valid_after", 32'(res_valid), 32'd0);

        // Double step sequence
        send(OpSetPos, 2'd0, 5'd15);
        send(OpSetPos, 2'd1, 5'd3);
        send(OpSetPos, 2'd2, 5'd0);
        check_eq("t2_setpos", 32'(pos), 32'(mkpos(0, 3, 15)));
        check_eq("t2_idle", 32'(cmd_ready), 32'd1);
        encrypt_full("t2a", 7, 0, 3, 16);
        encrypt_full("t2b", 7, 0, 4, 17);
        encrypt_full("t2c", 7, 1, 5, 18);

        // Wrap without carry
        send(OpSetPos, 2'd0, 5'd25);
        send(OpSetPos, 2'd1, 5'd25);
        send(OpSetPos, 2'd2, 5'd25);
        encrypt_full("t3", 11, 25, 25, 0);

        // Back-pressure in DONE with commands offered
        send(OpEncrypt, 2'd0, 5'd5);
        wait_result("t4");
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i % 2 == 0);
            cmd_op    = OpZero;
            tick();
            check_eq($sformatf("t4_data%0d", i), 32'(res_data), 32'(ref_enc(5, 1, 25, 25)));
            check_eq($sformatf("t4_ready%0d", i), 32'(cmd_ready), 32'd0);
            check_eq($sformatf("t4_valid%0d", i), 32'(res_valid), 32'd1);
        end
        cmd_valid = 1'b0;
        check_eq("t4_pos_kept", 32'(pos), 32'(mkpos(25, 25, 1)));
        ack();
        check_eq("t4_ready_after", 32'(cmd_ready), 32'd1);
        check_eq("t4_valid_after", 32'(res_valid), 32'd0);
        check_eq("t4_pos_after", 32'(pos), 32'(mkpos(25, 25, 1)));

        // Invalid letter and invalid / ignored configuration commands
        send(OpEncrypt, 2'd0, 5'd27);
        check_eq("t5_valid", 32'(res_valid), 32'd1);
        check_eq("t5_data", 32'(res_data), 32'd31);
        check_eq("t5_err", 32'(res_err), 32'd1);
        check_eq("t5_pos", 32'(pos), 32'(mkpos(25, 25, 1)));
        ack();
        check_eq("t5_err_clr", 32'(res_err), 32'd0);
        check_eq("t5_ready", 32'(cmd_ready), 32'd1);
        send(OpSetPos, 2'd1, 5'd30);
        check_eq("t5_setpos_bad", 32'(pos), 32'(mkpos(25, 25, 1)));
        send(OpSetPos, 2'd3, 5'd7);
        check_eq("t5_setpos_sel3", 32'(pos), 32'(mkpos(25, 25, 1)));
        send(OpNop, 2'd0, 5'd3);
        check_eq("t5_nop", 32'(pos), 32'(mkpos(25, 25, 1)));
        check_eq("t5_nop_ready", 32'(cmd_ready), 32'd1);
        send(OpZero, 2'd0, 5'd0);
        check_eq("t5_zero", 32'(pos), 32'd0);

        // Reset in the middle of an operation
        send(OpSetPos, 2'd0, 5'd9);
        send(OpEncrypt, 2'd0, 5'd3);
        tick();
        tick();
        tick();
        check_eq("t6_in_f2", 32'(dp_sel), 32'd2);
        check_eq("t6_pos_stepped", 32'(pos), 32'(mkpos(0, 0, 10)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_ready", 32'(cmd_ready), 32'd1);
        check_eq("t6_valid", 32'(res_valid), 32'd0);
        check_eq("t6_pos", 32'(pos), 32'd0);
        check_eq("t6_dp_in", 32'(dp_in), 32'd0);
        check_eq("t6_dp_sel", 32'(dp_sel), 32'd0);
        encrypt_full("t6_post", 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enigma_ctrl.md
ENIGMA_CTRL -- requirements
Module: enigma_ctrl

Interface
REQ-001 SHALL have parameters: NOTCH0, default 16, rotor-0 turnover position; NOTCH1, default 4, rotor-1 turnover position; ALPHA, default 26, alphabet size.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 ENCRYPT, 01 SET_POS, 10 ZERO, 11 NOP.
REQ-007 SHALL have port cmd_sel, input, 2 bits: rotor index 0..2 for SET_POS; value 3 ignored.
REQ-008 SHALL have port cmd_data, input, 5 bits: letter or position.
REQ-009 SHALL have port dp_sel, output, 2 bits: stage select (0..2 rotor, 3 reflector).
REQ-010 SHALL have port dp_dir, output, 1 bit: 0 forward, 1 backward.
REQ-011 SHALL have port dp_in, output, 5 bits: letter into the stage.
REQ-012 SHALL have port dp_offset, output, 5 bits: position of the selected rotor; 0 when dp_sel = 3.
REQ-013 SHALL have port dp_out, input, 5 bits: combinational stage result.
REQ-014 SHALL have port res_valid, output, 1 bit: result available.
REQ-015 SHALL have port res_ready, input, 1 bit: result consumed when res_valid and res_ready are both high.
REQ-016 SHALL have port res_data, output, 5 bits: result letter.
REQ-017 SHALL have port res_err, output, 1 bit: result flags an invalid letter.
REQ-018 SHALL have port pos, output, 15 bits: {pos2, pos1, pos0}, current rotor positions.

Function
REQ-019 The FSM SHALL have states IDLE, STEP, F0, F1, F2, REFL, B2, B1, B0, DONE.
REQ-020 cmd_ready SHALL be 1 only in IDLE.
REQ-021 SET_POS with cmd_data < 26 SHALL write pos[cmd_sel] at the accept edge; otherwise positions SHALL be unchanged. The FSM SHALL stay in IDLE.
REQ-022 ZERO SHALL clear all positions at the accept edge; NOP SHALL have no effect; both SHALL stay in IDLE.
REQ-023 ENCRYPT with cmd_data < 26 SHALL latch the letter into the data register and go to STEP.
REQ-024 ENCRYPT with cmd_data >= 26 SHALL go directly to DONE with res_data = 31 and res_err = 1, and SHALL NOT step the rotors.
REQ-025 STEP SHALL last one cycle and apply the rotor stepping rules:
- pos0 SHALL always advance.
- pos1 SHALL advance if pos0 == NOTCH0 or pos1 == NOTCH1 (double step).
- pos2 SHALL advance if pos1 == NOTCH1.
- All conditions SHALL be evaluated on pre-step values.
- Increments SHALL wrap 25 -> 0.
REQ-026 Stage cycles F0, F1, F2, REFL, B2, B1, B0 SHALL each last one cycle and latch dp_out into the data register at the cycle's end.
REQ-027 Stage cycles SHALL drive dp_sel = 0, 1, 2, 3, 2, 1, 0 and dp_dir = 0, 0, 0, 0, 1, 1, 1 respectively.
REQ-028 dp_in SHALL equal the data register in all states.
REQ-029 In non-stage states, dp_sel and dp_dir SHALL be 0.
REQ-030 Latency SHALL be fixed: res_valid rises 9 clock edges after the ENCRYPT accept edge (1 STEP + 7 stages + 1 edge into DONE).
REQ-031 In DONE, res_valid SHALL be 1, and res_data and res_err SHALL be held stable until the res_ready handshake.
REQ-032 On the res_ready handshake the FSM SHALL go to IDLE, with cmd_ready high the next cycle.
REQ-033 cmd_valid SHALL be ignored outside IDLE.
REQ-034 res_err SHALL clear on handshake.

Reset
REQ-035 When rst is high at a clock edge, the block SHALL enter IDLE, set all positions and the data register to 0, and clear res_valid and res_err, regardless of the current state. An operation in flight SHALL be discarded.
REQ-036 Output values after reset SHALL be: cmd_ready = 1, res_valid = 0, res_data = 0, res_err = 0, dp_sel = 0, dp_dir = 0, dp_in = 0, dp_offset = 0, pos = 0.

Structure
REQ-037 Shared package enigma_pkg SHALL hold:
- letter_t (5-bit) type
- cmd_op enum
- FSM state enum
- ALPHA, NOTCH0 and NOTCH1 defaults
REQ-038 Stepping and wrap logic SHALL be one combinational sub-module, enigma_stepper (inputs: three positions; outputs: three next positions).

Verification
REQ-039 Reset, ENCRYPT 0 -> pos = (0,0,1) as {pos2,pos1,pos0}, dp_sel trace 0,1,2,3,2,1,0, res_valid at edge 9.
REQ-040 SET_POS r0 = 15, r1 = 3, then three ENCRYPTs -> pos0/pos1/pos2 = 16/3/0, 17/4/0, 18/5/1 (double step).
REQ-041 SET_POS all rotors 25, ENCRYPT -> pos0/pos1/pos2 = 0/25/25 (wrap, no carry).
REQ-042 Hold res_ready = 0 for 5 cycles in DONE while pulsing cmd_valid -> res_data stable, cmd_ready = 0, no command taken; then res_ready = 1 -> cmd_ready = 1 next cycle.
REQ-043 ENCRYPT 27 -> res_valid next cycle, res_data = 31, res_err = 1, positions unchanged; SET_POS r1 = 30 -> pos unchanged.
REQ-044 rst asserted during F2 -> IDLE, pos = 0, res_valid = 0 the next cycle.
